// File: rtl/perf_counter_bank_pkg.sv
// Shared register map and CTRL bit positions for the performance-counter bank.
package perf_pkg;
  localparam logic [7:0] PERF_CTRL     = 8'h00;
  localparam logic [7:0] PERF_STATUS   = 8'h01;
  localparam logic [7:0] PERF_CYCLE    = 8'h02;
  localparam logic [7:0] PERF_EVT_BASE = 8'h03;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FRZ    = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_OVF_IE = 3;

  // Counter k: 0 is CYCLE, k>=1 is EVT(k-1).
  function automatic logic [7:0] cnt_addr(input int k);
    return (k == 0) ? PERF_CYCLE : PERF_EVT_BASE + 8'(k - 1);
  endfunction
endpackage

// File: rtl/perf_counter_bank_if.sv
// Word-addressed read/write port from the data-space splitter high half.
interface perf_counter_bank_if;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        wren;
  logic [63:0] rdata;

  modport master (output addr, wdata, wren, input rdata);
  modport slave  (input addr, wdata, wren, output rdata);
endinterface

// File: rtl/perf_counter_bank_counter.sv
// One loadable wrapping counter; ovf flags the increment that wraps to zero.
module perf_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);
  // Only a real increment can wrap; clr and load both win over it.
  assign ovf = inc && !load && !clr && (&value);

  always_ff @(posedge clk) begin
    if (rst || clr)  value <= '0;
    else if (load)   value <= load_val;
    else if (inc)    value <= value + CNT_W'(1);
  end
endmodule

// File: rtl/perf_counter_bank.sv
// Perf-counter responder: decode, CTRL/STATUS, counter array, 1-cycle registered read.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 64
) (
  input  logic                clk,
  input  logic                rst,
  perf_counter_bank_if.slave  bus,
  input  logic [NUM_EVT-1:0]  evt,
  output logic                irq_ovf
);
  logic [7:0]                    a;
  logic [3:0]                    ctrl;
  logic [NUM_EVT:0]              status;
  logic [NUM_EVT:0]              w1c;
  logic [NUM_EVT:0][CNT_W-1:0]   cnt_val;
  logic [NUM_EVT:0]              cnt_inc, cnt_load, cnt_ovf;
  logic                          wr_ctrl, wr_status, ctrl_clr, count_en;
  logic [63:0]                   rd_next;
  logic                          unused_addr_hi;

  assign a              = bus.addr[7:0];
  assign unused_addr_hi = ^bus.addr[63:8];
  assign wr_ctrl        = bus.wren && (a == PERF_CTRL);
  assign wr_status      = bus.wren && (a == PERF_STATUS);
  assign ctrl_clr       = wr_ctrl && bus.wdata[CTRL_CLR];
  assign count_en       = ctrl[CTRL_EN] && !ctrl[CTRL_FRZ];
  assign cnt_inc        = {evt & {NUM_EVT{count_en}}, count_en};
  assign w1c            = wr_status ? bus.wdata[NUM_EVT:0] : '0;

  genvar k;
  for (k = 0; k <= NUM_EVT; k++) begin : g_cnt
    assign cnt_load[k] = bus.wren && (a == cnt_addr(k));
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (cnt_inc[k]),
      .load     (cnt_load[k]),
      .load_val (bus.wdata[CNT_W-1:0]),
      .clr      (ctrl_clr),
      .value    (cnt_val[k]),
      .ovf      (cnt_ovf[k])
    );
  end

  always_comb begin
    rd_next = '0;
    if (a == PERF_CTRL)        rd_next[3:0]       = ctrl;
    else if (a == PERF_STATUS) rd_next[NUM_EVT:0] = status;
    else
      for (int i = 0; i <= NUM_EVT; i++)
        if (a == cnt_addr(i)) rd_next[CNT_W-1:0] = cnt_val[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      status    <= '0;
      irq_ovf   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl           <= bus.wdata[3:0];
        ctrl[CTRL_CLR] <= 1'b0;
      end
      // A fresh wrap re-sets its bit even if software clears it this cycle.
      status    <= (status & ~w1c) | cnt_ovf;
      irq_ovf   <= (|status) && ctrl[CTRL_OVF_IE];
      bus.rdata <= rd_next;
    end
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed table-driven bench for perf_counter_bank plus a reset-mid-count sequence.
module tb_perf_counter_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] evt;
  logic       irq_ovf;
  int         n_chk  = 0;
  int         n_fail = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  perf_counter_bank_if bus ();

  perf_counter_bank #(.NUM_EVT(4), .CNT_W(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .evt     (evt),
    .irq_ovf (irq_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  evt;
    logic [63:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit we, logic [63:0] a, logic [63:0] wd, logic [3:0] e,
                              logic [63:0] er, bit ei);
    vec_t v;
    v = '{we, a, wd, e, er, ei};
    vq.push_back(v);
  endfunction

  // One cycle: drive, take the edge, then compare rdata (read of this cycle's addr) and irq.
  task automatic step(input bit we, input logic [63:0] a, input logic [63:0] wd,
                      input logic [3:0] e, input bit chk, input logic [63:0] er,
                      input bit ei, input string nm);
    bus.wren  = we;
    bus.addr  = a;
    bus.wdata = wd;
    evt       = e;
    @(posedge clk);
    #1;
    if (chk) begin
      n_chk++;
      if (bus.rdata !== er) begin
        n_fail++;
        $display("FAIL %s rdata: got %h, want %h", nm, bus.rdata, er);
      end
      n_chk++;
      if (irq_ovf !== ei) begin
        n_fail++;
        $display("FAIL %s irq_ovf: got %b, want %b", nm, irq_ovf, ei);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wren = 1'b0; bus.addr = '0; bus.wdata = '0; evt = '0;
    step(0, 0, 0, 0, 1, 0, 0, "reset0");
    step(0, 0, 0, 0, 1, 0, 0, "reset1");
    rst = 1'b0;

    // Counting
    add(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 4'h1, 1, 0);
    add(0, 2, 0, 0, 10, 0);
    add(0, 3, 0, 0, 10, 0);
    add(0, 4, 0, 0, 0, 0);
    add(0, 5, 0, 0, 0, 0);
    add(0, 6, 0, 0, 0, 0);
    // Freeze, then clear with counting resumed
    add(1, 0, 3, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 4'hF, 3, 0);
    add(0, 3, 0, 0, 10, 0);
    add(0, 2, 0, 0, 16, 0);
    add(1, 0, 5, 0, 3, 0);
    add(0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0);
    add(0, 2, 0, 0, 2, 0);
    add(0, 3, 0, 0, 0, 0);
    // Wrap, STATUS, irq, W1C
    add(1, 4, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
    add(1, 0, 9, 0, 1, 0);
    add(0, 0, 0, 4'h2, 9, 0);
    add(0, 4, 0, 4'h2, ONES, 0);
    add(0, 1, 0, 0, 64'h4, 1);
    add(0, 4, 0, 0, 0, 1);
    add(1, 1, 64'h4, 0, 64'h4, 1);
    add(0, 1, 0, 0, 0, 0);
    // Collisions: load beats inc, same-cycle read/write, W1C vs new overflow
    add(1, 5, 100, 4'h4, 0, 0);
    add(0, 5, 0, 0, 100, 0);
    add(1, 2, 64'h1000, 0, 14, 0);
    add(0, 2, 0, 0, 64'h1000, 0);
    add(0, 2, 0, 0, 64'h1001, 0);
    add(1, 6, ONES, 0, 0, 0);
    add(0, 6, 0, 4'h8, ONES, 0);
    add(1, 6, ONES, 0, 0, 1);
    add(1, 1, 64'h10, 4'h8, 64'h10, 1);
    add(0, 1, 0, 0, 64'h10, 1);
    add(1, 1, 64'h1F, 0, 64'h10, 1);
    add(0, 1, 0, 0, 0, 0);
    // Idle and unmapped
    add(1, 0, 0, 0, 9, 0);
    for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 0);
    add(0, 2, 0, 0, 64'h100A, 0);
    add(0, 5, 0, 0, 100, 0);
    add(0, 64'h80, 0, 0, 0, 0);
    add(0, 7, 0, 0, 0, 0);
    add(1, 64'h80, ONES, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 64'h8000_0000_0000_0002, 0, 0, 64'h100A, 0);
    add(0, 6, 0, 0, 0, 0);
    add(0, 4, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0);

    foreach (vq[i])
      step(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].evt, 1,
           vq[i].exp_rd, vq[i].exp_irq, $sformatf("vec%0d", i));

    // Reset while counting with a sticky overflow pending
    step(1, 0, 9, 0, 0, 0, 0, "rm_en");
    step(1, 3, ONES, 0, 0, 0, 0, "rm_load");
    step(0, 0, 0, 4'h1, 1, 9, 0, "rm_wrap");
    step(0, 1, 0, 0, 1, 64'h2, 1, "rm_status");
    rst = 1'b1;
    step(1, 2, ONES, 4'hF, 1, 0, 0, "rm_rst");
    rst = 1'b0;
    step(0, 0, 0, 0, 1, 0, 0, "rm_ctrl");
    step(0, 1, 0, 0, 1, 0, 0, "rm_stat");
    step(0, 2, 0, 0, 1, 0, 0, "rm_cycle");
    step(0, 3, 0, 0, 1, 0, 0, "rm_evt0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
